// File: rtl/console_pkg.sv
// Shared console panel constants: key/switch bit positions, scan row numbers
// and the scan state encoding.
package console_pkg;

  localparam int unsigned WORD_W = 36;

  localparam int unsigned KEY_START     = 0;
  localparam int unsigned KEY_READ_IN   = 1;
  localparam int unsigned KEY_MEM_CONT  = 2;
  localparam int unsigned KEY_INST_CONT = 3;
  localparam int unsigned KEY_MEM_STOP  = 4;
  localparam int unsigned KEY_INST_STOP = 5;
  localparam int unsigned KEY_EXEC      = 6;
  localparam int unsigned KEY_IO_RESET  = 7;
  localparam int unsigned KEY_DEP       = 8;
  localparam int unsigned KEY_DEP_NXT   = 9;
  localparam int unsigned KEY_EX        = 10;
  localparam int unsigned KEY_EX_NXT    = 11;
  localparam int unsigned NKEYS         = KEY_EX_NXT + 1;

  localparam int unsigned SW_ADDR_STOP     = 0;
  localparam int unsigned SW_MEM_DISABLE   = 1;
  localparam int unsigned SW_REPEAT        = 2;
  localparam int unsigned SW_POWER         = 3;
  localparam int unsigned SW_RIM_MAINT     = 4;
  localparam int unsigned SW_REPEAT_BYPASS = 5;
  localparam int unsigned SW_ART3_MAINT    = 6;
  localparam int unsigned SW_SCT_MAINT     = 7;
  localparam int unsigned SW_SPLIT_CYC     = 8;
  localparam int unsigned NSW              = SW_SPLIT_CYC + 1;

  localparam int unsigned ROW_DATASW = 0;
  localparam int unsigned ROW_MAS    = 1;
  localparam int unsigned ROW_KEYS   = 2;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } scan_state_t;

endpackage

// File: rtl/console_key_debounce.sv
// One console key: frame-rate debounce counter with a one-clock press pulse.
module console_key_debounce
  import console_pkg::*;
#(
  parameter int unsigned DEB = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sample,
  output logic pulse
);

  localparam int unsigned CNT_W = 3;

  logic [CNT_W-1:0] cnt;
  logic             level;

  // Toggle only after DEB consecutive disagreeing samples; pulse on press only.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (en) begin
        if (sample == level) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEB - 1)) begin
          cnt   <= '0;
          level <= ~level;
          pulse <= ~level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/console_panel_scan.sv
// Console front-panel scanner: shifts light rows out and switch/key rows in.
// Optional CONSOLE_LAMP_TEST_EN adds lamp_test, forcing all lamps on.
module console_panel_scan
  import console_pkg::*;
#(
  parameter int unsigned NROWS  = 16,
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned DEB    = 3
) (
  input  logic         clk,
  input  logic         reset,
  output logic [3:0]   lrow,
  input  logic [0:35]  lword,
`ifdef CONSOLE_LAMP_TEST_EN
  input  logic         lamp_test,
`endif
  output logic         p_sclk,
  output logic         p_sdata,
  output logic         p_latch,
  input  logic         p_sdin,
  output logic [0:35]  datasw,
  output logic [18:35] mas,
  output logic [0:8]   sw,
  output logic [0:11]  keys,
  output logic         frame
);

  localparam int unsigned DIV_W = $clog2(2 * CLKDIV);
  localparam logic [DIV_W-1:0] DIV_RISE   = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0] DIV_HI     = DIV_W'(CLKDIV);
  localparam logic [DIV_W-1:0] DIV_COMMIT = DIV_W'(2 * CLKDIV - 2);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * CLKDIV - 1);
  localparam logic [3:0]       LROW_LAST  = 4'(NROWS - 1);

  scan_state_t      state;
  logic [DIV_W-1:0] div;
  logic [5:0]       bitcnt;
  logic [0:35]      shreg;
  logic [0:35]      insr;
  logic [0:35]      cap_datasw;
  logic [18:35]     cap_mas;
  logic [0:8]       cap_sw;
  logic [0:11]      cap_keys;
  logic [0:35]      load_word_c;
  logic [0:35]      row_in_c;
  logic             sample_c;
  logic             commit_c;

`ifdef CONSOLE_LAMP_TEST_EN
  assign load_word_c = lamp_test ? '1 : lword;
`else
  assign load_word_c = lword;
`endif

  // With CLKDIV=1 the last sample and the row end share a cycle, so capture sees it.
  assign sample_c = (state == SHIFT) && (div == DIV_HI);
  assign row_in_c = sample_c ? {insr[1:35], p_sdin} : insr;
  assign commit_c = (state == LATCH) && (div == DIV_COMMIT);
  assign p_sdata  = shreg[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      lrow       <= '0;
      div        <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      insr       <= '0;
      cap_datasw <= '0;
      cap_mas    <= '0;
      cap_sw     <= '0;
      cap_keys   <= '0;
      p_sclk     <= 1'b0;
      p_latch    <= 1'b0;
      datasw     <= '0;
      mas        <= '0;
      sw         <= '0;
      frame      <= 1'b0;
    end else begin
      frame <= 1'b0;
      unique case (state)
        LOAD: begin
          shreg  <= load_word_c;
          div    <= '0;
          bitcnt <= '0;
          p_sclk <= 1'b0;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (sample_c) begin
            insr  <= row_in_c;
            shreg <= {shreg[1:35], 1'b0};
          end
          if (div == DIV_LAST) begin
            div    <= '0;
            p_sclk <= 1'b0;
            if (bitcnt == 6'd35) begin
              if (lrow == 4'(ROW_DATASW)) begin
                cap_datasw <= row_in_c;
              end else if (lrow == 4'(ROW_MAS)) begin
                cap_mas <= row_in_c[0:17];
                cap_sw  <= row_in_c[18:26];
              end else if (lrow == 4'(ROW_KEYS)) begin
                cap_keys <= row_in_c[0:11];
              end
              if (lrow == LROW_LAST) begin
                p_latch <= 1'b1;
                state   <= LATCH;
              end else begin
                lrow  <= lrow + 4'd1;
                state <= LOAD;
              end
            end else begin
              bitcnt <= bitcnt + 6'd1;
            end
          end else begin
            div    <= div + 1'b1;
            p_sclk <= (div >= DIV_RISE);
          end
        end
        LATCH: begin
          // Outputs land so they are visible during the final latch cycle.
          if (commit_c) begin
            datasw <= cap_datasw;
            mas    <= cap_mas;
            sw     <= cap_sw;
            frame  <= 1'b1;
          end
          if (div == DIV_LAST) begin
            div     <= '0;
            p_latch <= 1'b0;
            lrow    <= '0;
            state   <= LOAD;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    console_key_debounce #(.DEB(DEB)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .en     (commit_c),
      .sample (cap_keys[k]),
      .pulse  (keys[k])
    );
  end

endmodule

// File: tb/tb_console_panel_scan.sv
// Bench for console_panel_scan: frame table, randomized frames, mid-frame reset.
module tb_console_panel_scan;

  localparam int NROWS  = 16;
  localparam int CLKDIV = 4;
  localparam int DEB    = 3;
  localparam int ROWT   = 1 + 72 * CLKDIV;
  localparam int FRAME  = NROWS * ROWT + 2 * CLKDIV;
  localparam int NTAB   = 5;
  localparam int NRAND  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   lrow;
  logic [0:35]  lword;
  logic         p_sclk, p_sdata, p_latch, p_sdin;
  logic [0:35]  datasw;
  logic [18:35] mas;
  logic [0:8]   sw;
  logic [0:11]  keys;
  logic         frame;
`ifdef CONSOLE_LAMP_TEST_EN
  logic         lamp_test = 1'b0;
`endif

  logic [0:35] light [16];
  logic [0:35] panel [16];

  always #5 clk = ~clk;
  assign lword = light[lrow];

  console_panel_scan #(.NROWS(NROWS), .CLKDIV(CLKDIV), .DEB(DEB)) dut (
    .clk     (clk),
    .reset   (reset),
    .lrow    (lrow),
    .lword   (lword),
`ifdef CONSOLE_LAMP_TEST_EN
    .lamp_test (lamp_test),
`endif
    .p_sclk  (p_sclk),
    .p_sdata (p_sdata),
    .p_latch (p_latch),
    .p_sdin  (p_sdin),
    .datasw  (datasw),
    .mas     (mas),
    .sw      (sw),
    .keys    (keys),
    .frame   (frame)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference model: timing from plain arithmetic, keys from sample history.
  bit           running = 0;
  logic         rst_q;
  int           cyc;
  int           m_pos, m_row, m_o, m_s, m_b, m_f;
  bit           m_latch, m_sclk, m_frame, m_diff;
  logic [0:11]  m_pulses;
  logic [0:35]  sent [3];
  logic [0:35]  seen_lamp0;
  logic [0:35]  exp_datasw;
  logic [18:35] exp_mas;
  logic [0:8]   exp_sw;
  logic [0:11]  kst;
  int           last_tog [12];
  logic [0:11]  khist [$];
  int           row_bad;
  string        first_bad;

  always @(posedge clk) begin
    rst_q <= reset;
    cyc   <= reset ? 0 : cyc + 1;
  end

  always @(negedge clk) begin
    if (running && rst_q === 1'b1) begin
      chk("reset_regs", {datasw, mas}, '0);
      chk("reset_ctl", {sw, keys, lrow, p_sclk, p_sdata, p_latch, frame}, '0);
      exp_datasw = '0; exp_mas = '0; exp_sw = '0; kst = '0;
      for (int k = 0; k < 12; k++) last_tog[k] = 0;
      khist.delete();
      row_bad = 0;
    end else if (running && rst_q === 1'b0) begin
      m_pos    = cyc % FRAME;
      m_latch  = m_pos >= NROWS * ROWT;
      m_row    = m_latch ? NROWS - 1 : m_pos / ROWT;
      m_o      = m_latch ? 0 : m_pos % ROWT;
      m_s      = m_o - 1;
      m_sclk   = !m_latch && m_o != 0 && (m_s % (2 * CLKDIV)) >= CLKDIV;
      m_frame  = m_pos == FRAME - 1;
      m_pulses = '0;
      if (!m_latch && m_o != 0) begin
        m_b = m_s / (2 * CLKDIV);
        if ((m_s % (2 * CLKDIV)) <= CLKDIV && p_sdata !== light[m_row][m_b]) begin
          if (row_bad == 0) first_bad = $sformatf("lamp bit %0d is %b", m_b, p_sdata);
          row_bad++;
        end
        if ((m_s % (2 * CLKDIV)) == CLKDIV) begin
          p_sdin = panel[m_row][m_b];
          if (m_row < 3) sent[m_row][m_b] = panel[m_row][m_b];
          if (m_row == 0) seen_lamp0[m_b] = p_sdata;
        end
      end
      if (m_frame) begin
        exp_datasw = sent[0];
        exp_mas    = sent[1][0:17];
        exp_sw     = sent[1][18:26];
        khist.push_back(sent[2][0:11]);
        m_f = khist.size();
        for (int k = 0; k < 12; k++) begin
          if (m_f - last_tog[k] >= DEB) begin
            m_diff = 1;
            for (int j = m_f - DEB; j < m_f; j++)
              if (khist[j][k] == kst[k]) m_diff = 0;
            if (m_diff) begin
              kst[k]      = ~kst[k];
              last_tog[k] = m_f;
              m_pulses[k] = kst[k];
            end
          end
        end
      end
      if ({lrow, p_sclk, p_latch, frame, keys} !== {4'(m_row), m_sclk, m_latch, m_frame, m_pulses} ||
          {datasw, mas, sw} !== {exp_datasw, exp_mas, exp_sw}) begin
        if (row_bad == 0)
          first_bad = $sformatf("cycle %0d lrow=%0d sclk=%b latch=%b frame=%b keys=%h need lrow=%0d sclk=%b latch=%b frame=%b keys=%h",
                                cyc + 1, lrow, p_sclk, p_latch, frame, keys, m_row, m_sclk, m_latch, m_frame, m_pulses);
        row_bad++;
      end
      if (m_frame || (!m_latch && m_o == ROWT - 1)) begin
        vectors++;
        if (row_bad != 0) begin
          miscompares++;
          $display("FAIL scan_row%0d: %0d cycles off model, first: %s; required 0", m_row, row_bad, first_bad);
        end
        row_bad = 0;
      end
    end
  end

  typedef struct {
    logic [0:35] r0, r1, r2;
    logic [0:35] datasw;
    logic [0:17] mas;
    logic [0:8]  sw;
    logic [0:11] keys;
  } tv_t;

  tv_t tbl [NTAB];

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < FRAME + 50);
    if (frame !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: no frame pulse in %0d cycles, one required", n);
    end
  endtask

  initial begin
    int          n;
    logic [63:0] tmp;
    logic [0:11] kw;
    logic [0:35] want0;

    // Row 2 key 0 held every frame; key 8 bounces 1,0,1,1,1.
    tbl[0] = '{36'o123456701234, {18'o123456, 9'b101010101, 9'o777}, {12'b1000_0000_1000, 24'hFFFFFF},
               36'o123456701234, 18'o123456, 9'b101010101, 12'b0000_0000_0000};
    tbl[1] = '{36'o123456701234, {18'o765432, 9'b010101010, 9'o000}, {12'b1000_0000_0000, 24'hFFFFFF},
               36'o123456701234, 18'o765432, 9'b010101010, 12'b0000_0000_0000};
    tbl[2] = '{36'o777700000777, {18'o000000, 9'b111111111, 9'o005}, {12'b1000_0000_1000, 24'hFFFFFF},
               36'o777700000777, 18'o000000, 9'b111111111, 12'b1000_0000_0000};
    tbl[3] = '{36'o000000000000, {18'o777777, 9'b000000001, 9'o000}, {12'b1000_0000_1000, 24'hFFFFFF},
               36'o000000000000, 18'o777777, 9'b000000001, 12'b0000_0000_0000};
    tbl[4] = '{36'o765432107654, {18'o000001, 9'b100000000, 9'o777}, {12'b1000_0000_1000, 24'hFFFFFF},
               36'o765432107654, 18'o000001, 9'b100000000, 12'b0000_0000_1000};

    reset = 1'b1;
    p_sdin = 1'b0;
    for (int j = 0; j < 16; j++) begin
      light[j] = 36'o444444555555;
      tmp = {$urandom, $urandom};
      panel[j] = tmp[35:0];
    end
    panel[0] = tbl[0].r0; panel[1] = tbl[0].r1; panel[2] = tbl[0].r2;
    repeat (2) @(posedge clk);
    running = 1;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NTAB; i++) begin
      panel[0] = tbl[i].r0; panel[1] = tbl[i].r1; panel[2] = tbl[i].r2;
      wait_frame(n);
      if (i == 0) begin
        chk("first_frame_cycle", 64'(n + 1), 64'(FRAME));
        chk("row0_lamp_bits", seen_lamp0, 36'o444444555555);
      end
      chk($sformatf("tab%0d_datasw", i), datasw, tbl[i].datasw);
      chk($sformatf("tab%0d_mas", i), mas, tbl[i].mas);
      chk($sformatf("tab%0d_sw", i), sw, tbl[i].sw);
      chk($sformatf("tab%0d_keys", i), keys, tbl[i].keys);
    end

    for (int r = 0; r < NRAND; r++) begin
      for (int j = 0; j < 16; j++) begin
        tmp = {$urandom, $urandom};
        light[j] = tmp[35:0];
        if (j != 2) begin
          tmp = {$urandom, $urandom};
          panel[j] = tmp[35:0];
        end
      end
      kw = panel[2][0:11];
      if ($urandom_range(0, 3) == 0) kw = 12'($urandom);
      panel[2] = {kw, 24'($urandom)};
      want0 = panel[0];
      wait_frame(n);
      chk($sformatf("rand%0d_period", r), 64'(n), 64'(FRAME));
      chk($sformatf("rand%0d_datasw", r), datasw, want0);
    end

    // Abort a frame in the high phase of row 5, bit 20.
    repeat (5 * ROWT + 1 + 20 * 2 * CLKDIV + CLKDIV + 1) @(negedge clk);
    chk("pre_reset_lrow", lrow, 64'd5);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {datasw, mas, sw, keys, frame, p_latch, p_sclk}, '0);
    chk("abort_lrow", lrow, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_lrow", lrow, 64'd0);
    want0 = panel[0];
    wait_frame(n);
    chk("frame_after_reset", 64'(n + 2), 64'(FRAME));
    chk("datasw_after_reset", datasw, want0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
